// File: rtl/aud_pkg.sv
// Shared audio definitions: sample/address widths and the playback FSM states.
// AUD_PLAYER_BOTH_CH_EN adds the right-slot states.
package aud_pkg;

    localparam int AUD_DATA_W = 16;
    localparam int AUD_ADDR_W = 20;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PAUS   = 3'd1,
        S_WAIT   = 3'd2,
        S_SEND   = 3'd3
`ifdef AUD_PLAYER_BOTH_CH_EN
        ,
        S_WAIT_R = 3'd4,
        S_SEND_R = 3'd5
`endif
    } aud_state_e;

endpackage

// File: rtl/aud_piso_tx.sv
// Parallel-in/serial-out shifter: load emits the MSB on the same edge, each shift
// emits the next bit, done once DATA_W bits have been emitted.
module aud_piso_tx #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic              clear,
    input  logic [DATA_W-1:0] data,
    output logic              sdo,
    output logic              done
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-2:0] sreg;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdo  <= 1'b0;
            sreg <= '0;
            cnt  <= '0;
        end else if (clear) begin
            sdo <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            sdo  <= data[DATA_W-1];
            sreg <= data[DATA_W-2:0];
            cnt  <= CNT_W'(1);
        end else if (shift_en && !done) begin
            sdo  <= sreg[DATA_W-2];
            sreg <= {sreg[DATA_W-3:0], 1'b0};
            cnt  <= cnt + CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(DATA_W));

endmodule

// File: rtl/aud_player.sv
// I2S-style playback: walks SRAM addresses and shifts each sample MSB-first in the
// left LRC slot. Define AUD_PLAYER_BOTH_CH_EN to replay the sample in the right slot.
module aud_player
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W,
    parameter int ADDR_W = AUD_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_end_address,
    input  logic [DATA_W-1:0] i_dac_data,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_dacdat,
    output logic              o_done,
    output logic [2:0]        o_state
);
    aud_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_d;
    logic              done_d;
    logic              lrc_r, rise;
    logic              tx_load, tx_shift, tx_clear, tx_done;
    logic [DATA_W-1:0] tx_data;

    assign rise    = ~lrc_r & i_lrc;
    assign o_state = state_q;

`ifdef AUD_PLAYER_BOTH_CH_EN
    logic              fall;
    logic [DATA_W-1:0] sample_q;

    assign fall    = lrc_r & ~i_lrc;
    // SRAM data is only valid at the left-slot rise; the right slot replays the latch.
    assign tx_data = (state_q == S_WAIT) ? i_dac_data : sample_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sample_q <= '0;
        end else if (state_q == S_WAIT && tx_load) begin
            sample_q <= i_dac_data;
        end
    end
`else
    assign tx_data = i_dac_data;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            o_address <= '0;
            o_done    <= 1'b0;
            lrc_r     <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_address <= addr_d;
            o_done    <= done_d;
            lrc_r     <= i_lrc;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = o_address;
        done_d   = 1'b0;
        tx_load  = 1'b0;
        tx_shift = 1'b0;
        tx_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    state_d = S_WAIT;
                    addr_d  = '0;
                end
            end
            S_PAUS: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_start) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUS;
                end else if (o_address == i_end_address) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (rise) begin
                    state_d = S_SEND;
                    tx_load = 1'b1;
                end
            end
            S_SEND: begin
                if (i_stop) begin
                    state_d  = S_IDLE;
                    tx_clear = 1'b1;
                end else if (i_pause) begin
                    state_d  = S_PAUS;
                    tx_clear = 1'b1;
                end else if (!i_lrc || tx_done) begin
`ifdef AUD_PLAYER_BOTH_CH_EN
                    // A slot ending on the falling edge must start the right slot now.
                    if (fall) begin
                        state_d = S_SEND_R;
                        tx_load = 1'b1;
                    end else begin
                        state_d  = S_WAIT_R;
                        tx_clear = 1'b1;
                    end
`else
                    state_d  = S_WAIT;
                    tx_clear = 1'b1;
                    addr_d   = o_address + ADDR_W'(1);
`endif
                end else begin
                    tx_shift = 1'b1;
                end
            end
`ifdef AUD_PLAYER_BOTH_CH_EN
            S_WAIT_R: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUS;
                end else if (fall) begin
                    state_d = S_SEND_R;
                    tx_load = 1'b1;
                end
            end
            S_SEND_R: begin
                if (i_stop) begin
                    state_d  = S_IDLE;
                    tx_clear = 1'b1;
                end else if (i_pause) begin
                    state_d  = S_PAUS;
                    tx_clear = 1'b1;
                end else if (i_lrc || tx_done) begin
                    state_d  = S_WAIT;
                    tx_clear = 1'b1;
                    addr_d   = o_address + ADDR_W'(1);
                end else begin
                    tx_shift = 1'b1;
                end
            end
`endif
            default: begin
                state_d  = S_IDLE;
                tx_clear = 1'b1;
            end
        endcase
    end

    aud_piso_tx #(
        .DATA_W(DATA_W)
    ) u_piso (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (tx_load),
        .shift_en(tx_shift),
        .clear   (tx_clear),
        .data    (tx_data),
        .sdo     (o_dacdat),
        .done    (tx_done)
    );

endmodule

// File: doc/aud_player.md
Name: aud_player

Overview:
- I2S-style playback transmitter, the DAC-side counterpart of the audio recorder.
- Walks a 20-bit SRAM address from 0 up to a caller-supplied end address.
- For each address, takes the SRAM read sample and shifts it out MSB-first on the codec DAC data line, one bit per bit-clock, in the left-channel half of each LRC frame.
- Sits between the SRAM read port and the WM8731-class codec's DACDAT/DACLRCK pins; the top-level FSM drives start/pause/stop.

Parameters:
- DATA_W, 16, sample width in bits (bits shifted per channel slot).
- ADDR_W, 20, SRAM address width.

Ports:
- i_clk  input  1  codec bit clock (BCLK); one serial bit per cycle.
- i_rst_n  input  1  asynchronous active-low reset.
- i_lrc  input  1  DAC LR clock; high = left slot.
- i_start  input  1  start (from IDLE) or resume (from PAUS), level-sampled.
- i_pause  input  1  pause request.
- i_stop  input  1  stop request.
- i_end_address  input  ADDR_W  first address not played (normally the recorder's stop address).
- i_dac_data  input  DATA_W  SRAM read data for o_address.
- o_address  output  ADDR_W  current SRAM read address.
- o_dacdat  output  1  serial DAC data.
- o_done  output  1  one-cycle pulse when playback reaches i_end_address.

Behaviour:
- Reset (async, i_rst_n low): state IDLE, o_address=0, o_dacdat=0, o_done=0, shift register/counter=0, lrc_r=0.
- Registers: lrc_r <= i_lrc every cycle; rise = !lrc_r & i_lrc. All outputs are registered.
- Event priority in every state: stop > pause > end-reached > rise.
- IDLE:
  - o_dacdat=0.
  - i_start -> WAIT with o_address <= 0.
  - Otherwise o_address holds.
- WAIT:
  - o_dacdat=0.
  - i_stop -> IDLE; i_pause -> PAUS.
  - o_address==i_end_address -> IDLE with o_done=1 for exactly one cycle.
  - rise -> SEND: o_dacdat <= i_dac_data[DATA_W-1], remaining bits loaded into shift register, counter <= 1.
- SEND:
  - Each cycle with i_lrc=1 and counter<DATA_W: o_dacdat <= next bit, counter+1.
  - So bits appear MSB-first on DATA_W consecutive cycles, starting at the edge where rise is detected (zero-cycle latency from the detection edge).
  - counter==DATA_W: o_dacdat <= 0, o_address <= o_address+1, -> WAIT.
- Boundary conditions in SEND:
  - i_lrc falls before counter==DATA_W: truncate; o_dacdat <= 0, o_address+1, -> WAIT.
  - i_pause: -> PAUS, o_dacdat <= 0, address held, so the sample is replayed in full after resume.
  - i_stop: -> IDLE, o_dacdat <= 0, address held.
- PAUS:
  - o_dacdat=0.
  - i_stop -> IDLE; i_start -> WAIT with address kept.
  - Simultaneous stop+start -> IDLE.
- Address arithmetic: modulo 2^ADDR_W. i_end_address is compared only in WAIT. i_end_address=0 with start -> done without any serial output.
- i_dac_data must be stable in the rise-detection cycle; it is not sampled afterwards.
- Reset asserted mid-word: o_dacdat forced 0 immediately (async).

Optional Feature:
- Macro: AUD_PLAYER_BOTH_CH_EN.
- Defined:
  - After the left slot completes, the block also waits for the falling LRC edge (lrc_r & !i_lrc).
  - It then shifts the same latched sample out again during the low (right) slot with identical timing and truncation rules.
  - o_address increments only after the right slot ends; the left-slot completion does not increment.
  - Pause/stop during the right slot behave as in SEND.
- Undefined: right slot always outputs 0; address increments after the left slot as described above.

Decomposition:
- Package aud_pkg holds:
  - state enum {S_IDLE, S_PAUS, S_WAIT, S_SEND}, plus S_WAIT_R/S_SEND_R under the macro;
  - localparams AUD_DATA_W=16 and AUD_ADDR_W=20, shared with the recorder.
- Sub-module aud_piso_tx: DATA_W parallel-in/serial-out shifter with load, shift enable, clear and a done flag. The top FSM owns the address, LRC edge detection and o_done.

Test Plan:
- Reset/idle: hold i_rst_n low, toggle i_lrc -> o_dacdat=0, o_address=0, o_done=0; no state change without i_start.
- Normal play: i_end_address=3, i_dac_data=16'hA5C3, pulse start.
  - After each LRC rise, o_dacdat = 1010010111000011 over 16 cycles, then 0.
  - o_address steps 0->1->2->3.
  - o_done pulses once; block returns to IDLE.
- Pause/resume: pause after 5 bits -> o_dacdat=0 next cycle, address held at 1; start -> at next rise the full 16'hA5C3 word replays from address 1.
- LRC truncation: i_lrc high for only 10 cycles -> 10 MSBs sent, remaining cycles 0, address +1.
- Stop then restart: stop at address 2 -> IDLE with address 2; start -> o_address=0 next cycle; i_end_address=0 -> o_done pulse with no serial bits.
- With AUD_PLAYER_BOTH_CH_EN: the same word appears in both left and right slots; address increments once per frame.
